// File: rtl/ram_responder.sv
// ram_responder
// Memory-side responder for the core RAM request bus. Accepts one read or
// write command at a time and serves each 32-bit word as two 16-bit beats on
// an external asynchronous SRAM (low half at {addr,0}, high half at {addr,1}).
//
// Ports:
//   clk, rst            clock (posedge) / synchronous active-high reset
//   ram_read/ram_write  command requests, held by initiator until ram_cack
//   ram_addr, ram_wdata word address and write data, sampled with command
//   ram_data            read data, held until the next read completes
//   ram_busy            command in progress
//   ram_cack            one-cycle pulse: command latched
//   ram_data_ready      one-cycle pulse: read data valid / write finished
//   sram_*              SRAM address, data bus and active-low strobes
//
// Every output is registered. The combinational process computes the next
// value of all state and outputs; the sequential process just loads them.
module ram_responder #(
    parameter int WAIT_CYC = 1          // extra cycles per beat, 1..7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_read,
    input  logic        ram_write,
    input  logic [15:0] ram_addr,
    input  logic [31:0] ram_wdata,
    output logic [31:0] ram_data,
    output logic        ram_busy,
    output logic        ram_cack,
    output logic        ram_data_ready,
    output logic [16:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    typedef enum logic [1:0] {IDLE, LO, HI} state_t;

    localparam logic [2:0] LAST = 3'(WAIT_CYC);

    state_t      state, state_nx;
    logic [2:0]  cnt, cnt_nx;
    logic        op_wr, op_wr_nx;
    logic [15:0] addr_q, addr_nx;
    logic [15:0] whi_q, whi_nx;
    logic [15:0] dlo_q, dlo_nx;
    logic [31:0] data_nx;
    logic        busy_nx, cack_nx, dr_nx;
    logic [16:0] saddr_nx;
    logic [15:0] dq_out_nx;
    logic        dq_oe_nx, ce_n_nx, oe_n_nx, we_n_nx;
    logic        last;

    assign last = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= 3'd0;
            op_wr          <= 1'b0;
            addr_q         <= 16'h0;
            whi_q          <= 16'h0;
            dlo_q          <= 16'h0;
            ram_data       <= 32'h0;
            ram_busy       <= 1'b0;
            ram_cack       <= 1'b0;
            ram_data_ready <= 1'b0;
            sram_addr      <= 17'h0;
            sram_dq_out    <= 16'h0;
            sram_dq_oe     <= 1'b0;
            sram_ce_n      <= 1'b1;
            sram_oe_n      <= 1'b1;
            sram_we_n      <= 1'b1;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            op_wr          <= op_wr_nx;
            addr_q         <= addr_nx;
            whi_q          <= whi_nx;
            dlo_q          <= dlo_nx;
            ram_data       <= data_nx;
            ram_busy       <= busy_nx;
            ram_cack       <= cack_nx;
            ram_data_ready <= dr_nx;
            sram_addr      <= saddr_nx;
            sram_dq_out    <= dq_out_nx;
            sram_dq_oe     <= dq_oe_nx;
            sram_ce_n      <= ce_n_nx;
            sram_oe_n      <= oe_n_nx;
            sram_we_n      <= we_n_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        op_wr_nx  = op_wr;
        addr_nx   = addr_q;
        whi_nx    = whi_q;
        dlo_nx    = dlo_q;
        data_nx   = ram_data;
        busy_nx   = ram_busy;
        cack_nx   = 1'b0;
        dr_nx     = 1'b0;
        saddr_nx  = sram_addr;
        dq_out_nx = sram_dq_out;
        dq_oe_nx  = sram_dq_oe;
        ce_n_nx   = sram_ce_n;
        oe_n_nx   = sram_oe_n;
        we_n_nx   = sram_we_n;

        case (state)
            IDLE: begin
                if (ram_read || ram_write) begin
                    // Read has priority; a concurrent write stays unacked and
                    // is picked up once the initiator is re-sampled.
                    op_wr_nx = !ram_read;
                    addr_nx  = ram_addr;
                    whi_nx   = ram_wdata[31:16];
                    cack_nx  = 1'b1;
                    busy_nx  = 1'b1;
                    ce_n_nx  = 1'b0;
                    saddr_nx = {ram_addr, 1'b0};
                    cnt_nx   = 3'd0;
                    oe_n_nx  = !ram_read;
                    dq_oe_nx = !ram_read;
                    we_n_nx  = 1'b1;        // beat cycle 0 is address setup
                    if (!ram_read)
                        dq_out_nx = ram_wdata[15:0];
                    state_nx = LO;
                end
            end
            LO: begin
                if (last) begin
                    if (!op_wr)
                        dlo_nx = sram_dq_in;
                    else
                        dq_out_nx = whi_q;
                    saddr_nx = {addr_q, 1'b1};
                    cnt_nx   = 3'd0;
                    we_n_nx  = 1'b1;
                    state_nx = HI;
                end else begin
                    // Next count is non-zero, so a write strobes from here on.
                    cnt_nx  = cnt + 3'd1;
                    we_n_nx = !op_wr;
                end
            end
            HI: begin
                if (last) begin
                    if (!op_wr)
                        data_nx = {sram_dq_in, dlo_q};
                    dr_nx    = 1'b1;
                    busy_nx  = 1'b0;
                    ce_n_nx  = 1'b1;
                    oe_n_nx  = 1'b1;
                    we_n_nx  = 1'b1;
                    dq_oe_nx = 1'b0;
                    cnt_nx   = 3'd0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx  = cnt + 3'd1;
                    we_n_nx = !op_wr;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder (WAIT_CYC=1) with a behavioural SRAM.
module tb_ram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_read, ram_write;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_data;
    logic        ram_busy, ram_cack, ram_data_ready;
    logic [16:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    logic [15:0] mem [0:131071];

    int total = 0;
    int bad   = 0;
    int viol  = 0;

    always #5 clk = ~clk;

    ram_responder #(.WAIT_CYC(1)) dut (
        .clk(clk), .rst(rst),
        .ram_read(ram_read), .ram_write(ram_write),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_data(ram_data), .ram_busy(ram_busy), .ram_cack(ram_cack),
        .ram_data_ready(ram_data_ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
        .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    // Asynchronous SRAM: reads combinational when selected, writes land at
    // the clock edge that ends a cycle with we_n low.
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0;

    always @(posedge clk)
        if (!sram_ce_n && !sram_we_n && sram_dq_oe)
            mem[sram_addr] = sram_dq_out;

    always @(negedge clk)
        if (!rst) begin
            if (!sram_oe_n && !sram_we_n) viol++;
            if (sram_dq_oe && !sram_oe_n) viol++;
        end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue a command, drop it once acked, wait for data_ready.
    // lat = negedges from the cack sample to the data_ready sample (-1: none).
    task automatic txn(input logic rd, input logic wr, input logic [15:0] a,
                       input logic [31:0] wd, output logic got,
                       output logic [31:0] rdata, output int lat);
        got = 1'b0;
        lat = -1;
        ram_read = rd; ram_write = wr; ram_addr = a; ram_wdata = wd;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ram_cack) begin got = 1'b1; break; end
        end
        ram_read = 1'b0; ram_write = 1'b0;
        if (got)
            for (int i = 1; i <= 20; i++) begin
                step();
                if (ram_data_ready) begin lat = i; break; end
            end
        rdata = ram_data;
    endtask

    logic        got;
    logic [31:0] rdata;
    int          lat;
    int          n_cack, n_dr;

    initial begin
        rst = 1'b1; ram_read = 1'b0; ram_write = 1'b0;
        ram_addr = 16'h0; ram_wdata = 32'h0;
        mem[17'h00014] = 16'h5678; mem[17'h00015] = 16'h1234;
        mem[17'h1FFFE] = 16'hAAAA; mem[17'h1FFFF] = 16'h5555;
        step(); step();

        // reset state
        chk("rst_ctl", {28'h0, ram_busy, ram_cack, ram_data_ready, sram_dq_oe}, 32'h0);
        chk("rst_strb", {29'h0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
        chk("rst_data", ram_data, 32'h0);
        chk("rst_addr", {15'h0, sram_addr}, 32'h0);
        chk("rst_dq", {16'h0, sram_dq_out}, 32'h0);

        // read 0x000A, cycle by cycle
        rst = 1'b0;
        ram_read = 1'b1; ram_addr = 16'h000A;
        step();                                   // after E
        chk("rd_cack", {31'h0, ram_cack}, 32'h1);
        chk("rd_busy", {31'h0, ram_busy}, 32'h1);
        chk("rd_addr_lo", {15'h0, sram_addr}, 32'h14);
        chk("rd_strb", {28'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'h2);
        ram_read = 1'b0;
        step();                                   // E+1
        chk("rd_cack_pulse", {31'h0, ram_cack}, 32'h0);
        step();                                   // E+2
        chk("rd_addr_hi", {15'h0, sram_addr}, 32'h15);
        step();                                   // E+3
        chk("rd_dr_early", {31'h0, ram_data_ready}, 32'h0);
        step();                                   // E+4
        chk("rd_dr", {31'h0, ram_data_ready}, 32'h1);
        chk("rd_data", ram_data, 32'h12345678);
        chk("rd_busy_end", {31'h0, ram_busy}, 32'h0);
        step();                                   // E+5
        chk("rd_dr_pulse", {31'h0, ram_data_ready}, 32'h0);
        chk("rd_data_hold", ram_data, 32'h12345678);
        chk("rd_strb_end", {29'h0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);

        // write 0xDEADBEEF to 0x0003, cycle by cycle
        ram_write = 1'b1; ram_addr = 16'h0003; ram_wdata = 32'hDEADBEEF;
        step();                                   // E
        chk("wr_cack", {31'h0, ram_cack}, 32'h1);
        chk("wr_setup", {28'h0, sram_oe_n, sram_we_n, sram_dq_oe, sram_ce_n}, 32'hE);
        chk("wr_lo", {15'h0, sram_addr, sram_dq_out}, {15'h0, 17'h6, 16'hBEEF});
        ram_write = 1'b0; ram_wdata = 32'h0;
        step();                                   // E+1
        chk("wr_we_lo", {31'h0, sram_we_n}, 32'h0);
        step();                                   // E+2
        chk("wr_hi", {15'h0, sram_addr, sram_dq_out}, {15'h0, 17'h7, 16'hDEAD});
        chk("wr_we_setup_hi", {31'h0, sram_we_n}, 32'h1);
        step();                                   // E+3
        chk("wr_we_hi", {31'h0, sram_we_n}, 32'h0);
        step();                                   // E+4
        chk("wr_dr", {31'h0, ram_data_ready}, 32'h1);
        chk("wr_data_kept", ram_data, 32'h12345678);
        chk("wr_dq_off", {31'h0, sram_dq_oe}, 32'h0);
        chk("wr_mem", {mem[17'h7], mem[17'h6]}, 32'hDEADBEEF);

        // read back 0x0003 (accepted on the edge right after data_ready)
        txn(1'b1, 1'b0, 16'h0003, 32'h0, got, rdata, lat);
        chk("rb_cack", {31'h0, got}, 32'h1);
        chk("rb_lat", lat, 32'd4);
        chk("rb_data", rdata, 32'hDEADBEEF);

        // read and write together: read first, write acked afterwards
        step();
        ram_read = 1'b1; ram_write = 1'b1; ram_addr = 16'h000A; ram_wdata = 32'hCAFEF00D;
        step();
        chk("rw_cack", {31'h0, ram_cack}, 32'h1);
        chk("rw_is_read", {30'h0, sram_oe_n, sram_dq_oe}, 32'h0);
        ram_read = 1'b0;
        n_cack = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (ram_cack) n_cack++;
        end
        chk("rw_no_wr_cack", n_cack, 32'd0);
        chk("rw_rd_data", {31'h0, ram_data_ready, ram_data}, {1'b1, 32'h12345678});
        step();
        chk("rw_wr_cack", {30'h0, ram_cack, sram_dq_oe}, 32'h3);
        ram_write = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("rw_wr_dr", {31'h0, ram_data_ready}, 32'h1);
        chk("rw_wr_mem", {mem[17'h15], mem[17'h14]}, 32'hCAFEF00D);

        // request re-pulsed while busy
        step();
        ram_read = 1'b1; ram_addr = 16'h0003;
        step();
        chk("busy_cack1", {31'h0, ram_cack}, 32'h1);
        ram_read = 1'b0;
        step();                                   // E+1
        ram_read = 1'b1;
        n_cack = 0; n_dr = 0;
        step();                                   // E+2
        if (ram_cack) n_cack++;
        step();                                   // E+3
        if (ram_cack) n_cack++;
        ram_read = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ram_cack) n_cack++;
            if (ram_data_ready) n_dr++;
        end
        chk("busy_no_cack", n_cack, 32'd0);
        chk("busy_one_dr", n_dr, 32'd1);
        chk("busy_data", ram_data, 32'hDEADBEEF);

        // address wrap at 0xFFFF
        ram_read = 1'b1; ram_addr = 16'hFFFF;
        step();
        chk("wrap_lo", {15'h0, sram_addr}, 32'h1FFFE);
        ram_read = 1'b0;
        step(); step();
        chk("wrap_hi", {15'h0, sram_addr}, 32'h1FFFF);
        step(); step();
        chk("wrap_data", {31'h0, ram_data_ready, ram_data}, {1'b1, 32'h5555AAAA});

        // reset during the HI beat
        ram_read = 1'b1; ram_addr = 16'h0003;
        step();                                   // E
        chk("abort_cack", {31'h0, ram_cack}, 32'h1);
        ram_read = 1'b0;
        step(); step(); step();                   // E+1..E+3
        rst = 1'b1;
        step();                                   // reset edge at E+4
        chk("abort_ctl", {29'h0, ram_busy, ram_cack, ram_data_ready}, 32'h0);
        chk("abort_strb", {28'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'hE);
        chk("abort_data", ram_data, 32'h0);
        rst = 1'b0;
        txn(1'b1, 1'b0, 16'h000A, 32'h0, got, rdata, lat);
        chk("post_cack", {31'h0, got}, 32'h1);
        chk("post_lat", lat, 32'd4);
        chk("post_data", rdata, 32'hCAFEF00D);

        chk("no_strobe_clash", viol, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
